// File: rtl/rc4_pkg.sv
// Shared types and default sizes for the rc4 keystream consumer.
package rc4_pkg;

  localparam int BYTE_W            = 8;
  localparam int LEN_W_DEF         = 16;
  localparam int KS_FIFO_DEPTH_DEF = 4;
  localparam int DROP_N_DEF        = 256;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rc4_stream_xor_if.sv
// Host-side bundle of rc4_stream_xor: message control, keystream, data in, data out.
interface rc4_stream_xor_if #(
  parameter int LEN_W = rc4_pkg::LEN_W_DEF
);
  import rc4_pkg::*;

  logic             start;
  logic [LEN_W-1:0] msg_length;
  logic             ks_valid;
  byte_t            ks_byte;
  logic             ks_ready;
  logic             din_valid;
  byte_t            din;
  logic             din_ready;
  logic             dout_valid;
  byte_t            dout;
  logic             dout_ready;
  logic [LEN_W-1:0] byte_cnt;
  logic             done;

  modport master (
    output start, msg_length, ks_valid, ks_byte, din_valid, din, dout_ready,
    input  ks_ready, din_ready, dout_valid, dout, byte_cnt, done
  );

  modport slave (
    input  start, msg_length, ks_valid, ks_byte, din_valid, din, dout_ready,
    output ks_ready, din_ready, dout_valid, dout, byte_cnt, done
  );

endinterface

// File: rtl/rc4_ks_fifo.sv
// Byte-wide synchronous FIFO buffering keystream between the rc4 core and the XOR stage.
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int DEPTH = KS_FIFO_DEPTH_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  push,
  input  byte_t wr_data,
  input  logic  pop,
  output byte_t rd_data,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  byte_t         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // NOTE: combinational next-state logic uses blocking '='; only clocked processes use '<='.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/rc4_stream_xor.sv
// XORs host bytes with buffered rc4 keystream (encrypt and decrypt alike), counting message bytes.
// Define RC4_DROP_EN to discard the first DROP_N keystream bytes of every message.
module rc4_stream_xor
  import rc4_pkg::*;
#(
  parameter int KS_FIFO_DEPTH = KS_FIFO_DEPTH_DEF,
  parameter int LEN_W         = LEN_W_DEF,
  parameter int DROP_N        = DROP_N_DEF
) (
  input logic             clk,
  input logic             rst_n,
  rc4_stream_xor_if.slave bus
);

  if (KS_FIFO_DEPTH < 2 || (KS_FIFO_DEPTH & (KS_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("KS_FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (DROP_N < 0) begin : g_bad_drop
    $error("DROP_N must be non-negative");
  end

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  byte_t            dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  logic  in_run, start_ok, dout_free, xfer, ks_acc, dropping;
  logic  fifo_push, fifo_pop, fifo_full, fifo_empty;
  byte_t fifo_head;

  assign in_run    = (state_q == ST_RUN);
  assign start_ok  = bus.start && !in_run;
  assign dout_free = !dout_valid_q || bus.dout_ready;

  assign bus.din_ready = in_run && !dropping && !fifo_empty && (cnt_q < len_q) && dout_free;
  assign xfer          = bus.din_valid && bus.din_ready;
  assign fifo_pop      = xfer;
  assign bus.ks_ready  = in_run && (dropping || !fifo_full || fifo_pop);
  assign ks_acc        = bus.ks_valid && bus.ks_ready;
  assign fifo_push     = ks_acc && !dropping;

`ifdef RC4_DROP_EN
  localparam int DROP_W = $clog2(DROP_N + 2);

  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  assign dropping = (drop_cnt_q != DROP_W'(DROP_N));

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (start_ok)              drop_cnt_d = '0;
    else if (ks_acc && dropping) drop_cnt_d = drop_cnt_q + DROP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end
`else
  assign dropping = 1'b0;
`endif

  rc4_ks_fifo #(.DEPTH(KS_FIFO_DEPTH)) u_ks_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (start_ok),
    .push    (fifo_push),
    .wr_data (bus.ks_byte),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          len_d   = bus.msg_length;
          cnt_d   = '0;
          state_d = (bus.msg_length == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          dout_d       = bus.din ^ fifo_head;
          dout_valid_d = 1'b1;
          cnt_d        = cnt_q + LEN_W'(1);
        end else if (bus.dout_ready) begin
          dout_valid_d = 1'b0;
        end
        // Final byte already taken and the output stage is draining this cycle.
        if (cnt_q == len_q && dout_free) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.dout_valid = dout_valid_q;
  assign bus.dout       = dout_q;
  assign bus.byte_cnt   = cnt_q;
  assign bus.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_rc4_stream_xor.sv
// Scoreboard bench for rc4_stream_xor: directed keystream/data vectors with hand-computed results.
module tb_rc4_stream_xor;
  import rc4_pkg::*;

  localparam int DEPTH     = 4;
  localparam int LEN_W     = 16;
  localparam int TB_DROP_N = 2;
  localparam int BUDGET    = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rc4_stream_xor_if #(.LEN_W(LEN_W)) bus ();

  rc4_stream_xor #(
    .KS_FIFO_DEPTH (DEPTH),
    .LEN_W         (LEN_W),
    .DROP_N        (TB_DROP_N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  byte_t ks_src[$];
  byte_t din_src[$];
  byte_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: compares every accepted output byte against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.dout_valid && bus.dout_ready) begin
      check("scoreboard_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("dout", bus.dout, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic vec(input byte_t ks, input byte_t d, input byte_t expd);
    ks_src.push_back(ks);
    din_src.push_back(d);
    exp_q.push_back(expd);
  endtask

  task automatic add_drop_prefix();
`ifdef RC4_DROP_EN
    for (int i = 0; i < TB_DROP_N; i++) ks_src.push_back(byte_t'(8'hC0 + i));
`endif
  endtask

  task automatic start_msg(input logic [LEN_W-1:0] len);
    bus.start      = 1'b1;
    bus.msg_length = len;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Offers queued keystream and data each cycle; optionally stalls dout_ready once output appears.
  task automatic run_stream(input int stall_len, input byte_t stall_dout);
    int    cyc    = 0;
    int    stalls = 0;
    logic  ks_hs, din_hs;
    byte_t drop_b;
    while ((ks_src.size() != 0 || din_src.size() != 0 || exp_q.size() != 0) && cyc < BUDGET) begin
      bus.ks_valid  = (ks_src.size() != 0);
      bus.din_valid = (din_src.size() != 0);
      if (ks_src.size() != 0)  bus.ks_byte = ks_src[0];
      if (din_src.size() != 0) bus.din     = din_src[0];
      if (bus.dout_valid && stalls < stall_len) begin
        bus.dout_ready = 1'b0;
        stalls++;
      end else begin
        bus.dout_ready = 1'b1;
      end
      @(negedge clk);
      if (!bus.dout_ready) begin
        check("bp_dout_hold", bus.dout, stall_dout);
        check("bp_dout_valid", bus.dout_valid, 1);
        check("bp_din_ready", bus.din_ready, 0);
        if (stalls >= DEPTH) check("bp_ks_ready_full", bus.ks_ready, 0);
      end
      ks_hs  = bus.ks_valid && bus.ks_ready;
      din_hs = bus.din_valid && bus.din_ready;
      @(posedge clk); #1;
      if (ks_hs)  drop_b = ks_src.pop_front();
      if (din_hs) drop_b = din_src.pop_front();
      cyc++;
    end
    bus.ks_valid   = 1'b0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    check("stream_within_budget", cyc < BUDGET, 1);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.msg_length = '0;
    bus.ks_valid   = 1'b1;
    bus.ks_byte    = 8'h5A;
    bus.din_valid  = 1'b1;
    bus.din        = 8'hA5;
    bus.dout_ready = 1'b1;

    // Reset state with valids asserted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ks_ready", bus.ks_ready, 0);
    check("rst_din_ready", bus.din_ready, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_byte_cnt", bus.byte_cnt, 0);
    check("rst_done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ks_ready", bus.ks_ready, 0);
    @(posedge clk); #1;
    bus.ks_valid  = 1'b0;
    bus.din_valid = 1'b0;

    // Basic message.
    start_msg(4);
    add_drop_prefix();
    vec(8'h11, 8'h61, 8'h70);
    vec(8'h22, 8'h62, 8'h40);
    vec(8'h33, 8'h63, 8'h50);
    vec(8'h44, 8'h64, 8'h20);
    run_stream(0, 8'h00);
    check("basic_done", bus.done, 1);
    check("basic_byte_cnt", bus.byte_cnt, 4);
    check("basic_dout_valid_clear", bus.dout_valid, 0);
    bus.ks_valid  = 1'b1;
    bus.din_valid = 1'b1;
    @(negedge clk);
    check("done_din_ready", bus.din_ready, 0);
    check("done_ks_ready", bus.ks_ready, 0);
    @(posedge clk); #1;
    bus.ks_valid  = 1'b0;
    bus.din_valid = 1'b0;
    check("done_byte_cnt_held", bus.byte_cnt, 4);

    // Round trip: ciphertext back through the same keystream.
    start_msg(4);
    add_drop_prefix();
    vec(8'h11, 8'h70, 8'h61);
    vec(8'h22, 8'h40, 8'h62);
    vec(8'h33, 8'h50, 8'h63);
    vec(8'h44, 8'h20, 8'h64);
    run_stream(0, 8'h00);
    check("rt_done", bus.done, 1);
    check("rt_byte_cnt", bus.byte_cnt, 4);

    // Backpressure long enough for the keystream FIFO to fill.
    start_msg(8);
    add_drop_prefix();
    vec(8'h11, 8'h61, 8'h70);
    vec(8'h22, 8'h62, 8'h40);
    vec(8'h33, 8'h63, 8'h50);
    vec(8'h44, 8'h64, 8'h20);
    vec(8'h55, 8'h65, 8'h30);
    vec(8'h66, 8'h66, 8'h00);
    vec(8'h77, 8'h67, 8'h10);
    vec(8'h88, 8'h68, 8'hE0);
    run_stream(DEPTH + 1, 8'h70);
    check("bp_done", bus.done, 1);
    check("bp_byte_cnt", bus.byte_cnt, 8);

    // Starved keystream.
    start_msg(1);
    bus.ks_valid  = 1'b0;
    bus.din_valid = 1'b1;
    bus.din       = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("starve_din_ready", bus.din_ready, 0);
      check("starve_dout_valid", bus.dout_valid, 0);
      @(posedge clk); #1;
    end
    bus.din_valid = 1'b0;
    add_drop_prefix();
    vec(8'hFF, 8'h5A, 8'hA5);
    run_stream(0, 8'h00);
    check("starve_done", bus.done, 1);
    check("starve_byte_cnt", bus.byte_cnt, 1);

    // Zero-length message from IDLE.
    do_reset();
    check("zero_pre_done", bus.done, 0);
    start_msg(0);
    check("zero_done", bus.done, 1);
    check("zero_byte_cnt", bus.byte_cnt, 0);
    bus.ks_valid  = 1'b1;
    bus.din_valid = 1'b1;
    @(negedge clk);
    check("zero_ks_ready", bus.ks_ready, 0);
    check("zero_din_ready", bus.din_ready, 0);
    check("zero_dout_valid", bus.dout_valid, 0);
    @(posedge clk); #1;
    bus.ks_valid  = 1'b0;
    bus.din_valid = 1'b0;

    // Start during RUN is ignored.
    start_msg(2);
    start_msg(5);
    add_drop_prefix();
    vec(8'h01, 8'h10, 8'h11);
    vec(8'h02, 8'h20, 8'h22);
    run_stream(0, 8'h00);
    check("ignore_start_done", bus.done, 1);
    check("ignore_start_byte_cnt", bus.byte_cnt, 2);

    // Reset mid-message with a byte pending at the output.
    start_msg(4);
    add_drop_prefix();
    vec(8'hA1, 8'h0F, 8'hAE);
    ks_src.push_back(8'hA2);
    run_stream(0, 8'h00);
    bus.din_valid  = 1'b1;
    bus.din        = 8'h33;
    bus.dout_ready = 1'b0;
    @(negedge clk);
    check("mid_din_ready", bus.din_ready, 1);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    check("mid_dout", bus.dout, 8'h91);
    check("mid_dout_valid", bus.dout_valid, 1);
    check("mid_byte_cnt", bus.byte_cnt, 2);
    bus.ks_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ks_ready", bus.ks_ready, 0);
    check("mid_rst_din_ready", bus.din_ready, 0);
    check("mid_rst_dout_valid", bus.dout_valid, 0);
    check("mid_rst_dout", bus.dout, 0);
    check("mid_rst_byte_cnt", bus.byte_cnt, 0);
    check("mid_rst_done", bus.done, 0);
    rst_n          = 1'b1;
    bus.ks_valid   = 1'b0;
    bus.dout_ready = 1'b1;

`ifdef RC4_DROP_EN
    // First TB_DROP_N keystream bytes are discarded.
    start_msg(1);
    ks_src.push_back(8'hAA);
    ks_src.push_back(8'hBB);
    vec(8'h11, 8'h50, 8'h41);
    run_stream(0, 8'h00);
    check("drop_done", bus.done, 1);
    check("drop_byte_cnt", bus.byte_cnt, 1);
`endif

    @(posedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
